// File: rtl/sram_bus_adapter.sv
// Bridges split read/write valid-ready channels onto a single-port SRAM with byte mask
// and registered read data; range-checks byte addresses and returns error-flagged beats.
//
// state   | meaning
// IDLE    | arbitrate pending read/write, issue SRAM access on the grant cycle
// RD_RESP | hold read-data beat (sram_dout or 0 on error) until r_data_ready
// WR_RESP | hold write response until w_resp_ready
module sram_bus_adapter #(
  parameter int data_width      = 32,
  parameter int bus_addr_width  = 32,
  parameter int sram_addr_width = 8,
  parameter logic [bus_addr_width-1:0] base_addr = '0
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       r_addr_valid,
  output logic                       r_addr_ready,
  input  logic [bus_addr_width-1:0]  r_addr,
  output logic                       r_data_valid,
  input  logic                       r_data_ready,
  output logic [data_width-1:0]      r_data,
  output logic                       r_resp,
  input  logic                       w_addr_valid,
  output logic                       w_addr_ready,
  input  logic [bus_addr_width-1:0]  w_addr,
  input  logic                       w_data_valid,
  output logic                       w_data_ready,
  input  logic [data_width-1:0]      w_data,
  input  logic [3:0]                 w_strobe,
  output logic                       w_resp_valid,
  input  logic                       w_resp_ready,
  output logic                       w_resp,
  output logic                       sram_en,
  output logic                       sram_wen,
  output logic [3:0]                 sram_wmask,
  output logic [sram_addr_width-1:0] sram_addr,
  output logic [data_width-1:0]      sram_din,
  input  logic [data_width-1:0]      sram_dout
);

  localparam int aw = bus_addr_width;
  // Upper bound kept one bit wider so a window ending at 2^aw does not wrap.
  localparam logic [aw:0] win_lo = {1'b0, base_addr};
  localparam logic [aw:0] win_hi = win_lo + ((aw+1)'(1) << (sram_addr_width + 2));

  typedef enum logic [1:0] {IDLE, RD_RESP, WR_RESP} state_t;

  state_t state_q, state_d;
  logic   prio_q, prio_d;       // 0 = read wins next conflict, 1 = write wins
  logic   r_resp_q, r_resp_d;
  logic   w_resp_q, w_resp_d;

  function automatic logic in_range(input logic [aw-1:0] a);
    return ({1'b0, a} >= win_lo) && ({1'b0, a} < win_hi);
  endfunction

  function automatic logic [sram_addr_width-1:0] word_idx(input logic [aw-1:0] a);
    return sram_addr_width'((a - base_addr) >> 2);
  endfunction

  logic rd_req, wr_req, grant_rd, grant_wr, r_hit, w_hit;

  // Gating with resetn keeps sram_en low while reset is held.
  assign rd_req   = r_addr_valid && resetn && (state_q == IDLE);
  assign wr_req   = w_addr_valid && w_data_valid && resetn && (state_q == IDLE);
  assign grant_rd = rd_req && (!wr_req || !prio_q);
  assign grant_wr = wr_req && (!rd_req || prio_q);
  assign r_hit    = in_range(r_addr);
  assign w_hit    = in_range(w_addr);

  assign r_resp = r_resp_q;
  assign w_resp = w_resp_q;
  assign r_data = (state_q == RD_RESP && !r_resp_q) ? sram_dout : '0;

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    r_resp_d     = r_resp_q;
    w_resp_d     = w_resp_q;
    r_addr_ready = 1'b0;
    w_addr_ready = 1'b0;
    w_data_ready = 1'b0;
    r_data_valid = 1'b0;
    w_resp_valid = 1'b0;
    sram_en      = 1'b0;
    sram_wen     = 1'b0;
    sram_wmask   = 4'h0;
    sram_addr    = '0;
    sram_din     = '0;
    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          w_addr_ready = 1'b1;
          w_data_ready = 1'b1;
          sram_en      = w_hit;
          sram_wen     = w_hit;
          sram_wmask   = w_hit ? w_strobe : 4'h0;
          sram_din     = w_data;
          sram_addr    = word_idx(w_addr);
          w_resp_d     = !w_hit;
          state_d      = WR_RESP;
        end else if (grant_rd) begin
          r_addr_ready = 1'b1;
          sram_en      = r_hit;
          sram_addr    = word_idx(r_addr);
          r_resp_d     = !r_hit;
          state_d      = RD_RESP;
        end
        if (rd_req && wr_req) prio_d = ~prio_q;
      end
      RD_RESP: begin
        r_data_valid = 1'b1;
        if (r_data_ready) state_d = IDLE;
      end
      WR_RESP: begin
        w_resp_valid = 1'b1;
        if (w_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      r_resp_q <= 1'b0;
      w_resp_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      r_resp_q <= r_resp_d;
      w_resp_q <= w_resp_d;
    end
  end

endmodule

// File: tb/tb_sram_bus_adapter.sv
// Bench for sram_bus_adapter: SRAM model, transaction-level reference model checked
// every cycle, and directed scenarios with literal expectations.
module tb_sram_bus_adapter;
  localparam longint BASE = 0;
  localparam longint WIN  = 4 * 256;

  logic        clock = 1'b0, resetn = 1'b0;
  logic        r_addr_valid, r_addr_ready, r_data_valid, r_data_ready, r_resp;
  logic [31:0] r_addr, r_data;
  logic        w_addr_valid, w_addr_ready, w_data_valid, w_data_ready;
  logic        w_resp_valid, w_resp_ready, w_resp;
  logic [31:0] w_addr, w_data;
  logic [3:0]  w_strobe, sram_wmask;
  logic        sram_en, sram_wen;
  logic [7:0]  sram_addr;
  logic [31:0] sram_din, sram_dout;

  always #5 clock = ~clock;

  sram_bus_adapter dut (
    .clock(clock), .resetn(resetn),
    .r_addr_valid(r_addr_valid), .r_addr_ready(r_addr_ready), .r_addr(r_addr),
    .r_data_valid(r_data_valid), .r_data_ready(r_data_ready), .r_data(r_data), .r_resp(r_resp),
    .w_addr_valid(w_addr_valid), .w_addr_ready(w_addr_ready), .w_addr(w_addr),
    .w_data_valid(w_data_valid), .w_data_ready(w_data_ready), .w_data(w_data),
    .w_strobe(w_strobe), .w_resp_valid(w_resp_valid), .w_resp_ready(w_resp_ready),
    .w_resp(w_resp), .sram_en(sram_en), .sram_wen(sram_wen), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // SRAM: single port, byte mask, registered read data.
  logic [31:0] sram_mem [256];
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wen) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask[b]) sram_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
      end else begin
        sram_dout <= sram_mem[sram_addr];
      end
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: one outstanding transaction, expected beat computed at grant.
  logic [31:0] gold [256];
  bit          m_busy = 0, m_wr = 0, m_prio = 0;
  logic        m_resp;
  logic [31:0] m_data;

  function automatic bit hit(input logic [31:0] a);
    return (longint'(a) >= BASE) && (longint'(a) < BASE + WIN);
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'((longint'(a) - BASE) / 4);
  endfunction

  always @(negedge clock) begin
    if (!resetn) begin
      chk("rst_en", sram_en, 0);
      chk("rst_rdv", r_data_valid, 0);
      chk("rst_wrv", w_resp_valid, 0);
      chk("rst_rrdy", r_addr_ready, 0);
      chk("rst_wrdy", w_addr_ready, 0);
      m_busy = 0;
      m_prio = 0;
    end else if (!m_busy) begin
      bit rd, wr, gr, gw, h;
      rd = r_addr_valid;
      wr = w_addr_valid && w_data_valid;
      gr = rd && (!wr || !m_prio);
      gw = wr && (!rd || m_prio);
      chk("idle_rdv", r_data_valid, 0);
      chk("idle_wrv", w_resp_valid, 0);
      chk("r_addr_ready", r_addr_ready, gr);
      chk("w_addr_ready", w_addr_ready, gw);
      chk("w_data_ready", w_data_ready, gw);
      if (gr) begin
        h = hit(r_addr);
        chk("rd_en", sram_en, h);
        if (h) begin
          chk("rd_wen", sram_wen, 0);
          chk("rd_addr", sram_addr, 32'(idx(r_addr)));
          m_data = gold[idx(r_addr)];
        end else m_data = 0;
        m_resp = !h; m_busy = 1; m_wr = 0;
      end else if (gw) begin
        h = hit(w_addr);
        chk("wr_en", sram_en, h);
        if (h) begin
          chk("wr_wen", sram_wen, 1);
          chk("wr_mask", sram_wmask, w_strobe);
          chk("wr_din", sram_din, w_data);
          chk("wr_addr", sram_addr, 32'(idx(w_addr)));
          for (int b = 0; b < 4; b++)
            if (w_strobe[b]) gold[idx(w_addr)][8*b +: 8] = w_data[8*b +: 8];
        end
        m_resp = !h; m_busy = 1; m_wr = 1;
      end else begin
        chk("idle_en", sram_en, 0);
      end
      if (rd && wr) m_prio = !m_prio;
    end else begin
      chk("busy_rrdy", r_addr_ready, 0);
      chk("busy_wrdy", w_addr_ready, 0);
      chk("busy_drdy", w_data_ready, 0);
      chk("busy_en", sram_en, 0);
      if (!m_wr) begin
        chk("rd_valid", r_data_valid, 1);
        chk("rd_wrv", w_resp_valid, 0);
        chk("r_data", r_data, m_data);
        chk("r_resp", r_resp, m_resp);
        if (r_data_ready) m_busy = 0;
      end else begin
        chk("wr_valid", w_resp_valid, 1);
        chk("wr_rdv", r_data_valid, 0);
        chk("w_resp", w_resp, m_resp);
        if (w_resp_ready) m_busy = 0;
      end
    end
  end

  task automatic issue_read(input logic [31:0] a);
    bit got = 0;
    r_addr = a; r_addr_valid = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (r_addr_ready) begin got = 1; break; end
    end
    if (!got) chk("rd_grant_timeout", 0, 1);
    @(posedge clock); #1 r_addr_valid = 0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic rs,
                         output int lat);
    bit got = 0;
    issue_read(a);
    lat = 0; d = 'x; rs = 1'bx;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      lat++;
      if (r_data_valid) begin d = r_data; rs = r_resp; got = 1; break; end
    end
    if (!got) chk("rd_data_timeout", 0, 1);
    @(posedge clock); #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic rs, output logic [7:0] ix);
    bit got = 0;
    w_addr = a; w_data = d; w_strobe = s; w_addr_valid = 1; w_data_valid = 1;
    ix = 'x; rs = 1'bx;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (w_addr_ready) begin ix = sram_addr; got = 1; break; end
    end
    if (!got) chk("wr_grant_timeout", 0, 1);
    @(posedge clock); #1 w_addr_valid = 0; w_data_valid = 0;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (w_resp_valid) begin rs = w_resp; got = 1; break; end
    end
    if (!got) chk("wr_resp_timeout", 0, 1);
    @(posedge clock); #1;
  endtask

  // Read and write presented together; reports which side was granted first.
  task automatic conflict(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] wd,
                          output int first);
    bit dr = 0, dw = 0, gr, gw;
    first = -1;
    r_addr = ra; r_addr_valid = 1;
    w_addr = wa; w_data = wd; w_strobe = 4'hF; w_addr_valid = 1; w_data_valid = 1;
    for (int i = 0; i < 60 && !(dr && dw); i++) begin
      @(negedge clock);
      gr = r_addr_ready; gw = w_addr_ready;
      if (first < 0 && gr) first = 0;
      if (first < 0 && gw) first = 1;
      @(posedge clock); #1;
      if (gr) begin r_addr_valid = 0; dr = 1; end
      if (gw) begin w_addr_valid = 0; w_data_valid = 0; dw = 1; end
    end
    if (!(dr && dw)) chk("conflict_timeout", 0, 1);
    repeat (3) @(posedge clock);
    #1;
  endtask

  logic [31:0] d;
  logic        rs;
  logic [7:0]  ix;
  int          lat, first;

  initial begin
    for (int i = 0; i < 256; i++) begin sram_mem[i] = 0; gold[i] = 0; end
    sram_dout = 0;
    r_addr_valid = 0; r_addr = 0; r_data_ready = 1;
    w_addr_valid = 0; w_data_valid = 0; w_addr = 0; w_data = 0; w_strobe = 0;
    w_resp_ready = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_r_data", r_data, 0);
    chk("rst_r_resp", r_resp, 0);
    chk("rst_w_resp", w_resp, 0);
    @(posedge clock); #1 resetn = 1;

    do_write(32'h10, 32'hDEADBEEF, 4'hF, rs, ix);
    chk("t1_wresp", rs, 0);
    chk("t1_widx", ix, 8'h04);
    do_read(32'h10, d, rs, lat);
    chk("t1_rdata", d, 32'hDEADBEEF);
    chk("t1_rresp", rs, 0);
    chk("t1_latency", lat, 1);

    do_write(32'h10, 32'h0000AA00, 4'h2, rs, ix);
    chk("t2_wresp", rs, 0);
    do_read(32'h10, d, rs, lat);
    chk("t2_rdata", d, 32'hDEADAAEF);

    conflict(32'h4, 32'h8, 32'h11223344, first);
    chk("t3_first_read", first, 0);
    conflict(32'h4, 32'h8, 32'h55667788, first);
    chk("t3_first_write", first, 1);
    do_read(32'h8, d, rs, lat);
    chk("t3_rdata", d, 32'h55667788);

    r_data_ready = 0;
    issue_read(32'h10);
    r_addr = 32'h10; r_addr_valid = 1;
    repeat (5) begin
      @(negedge clock);
      chk("t4_valid", r_data_valid, 1);
      chk("t4_data", r_data, 32'hDEADAAEF);
      chk("t4_resp", r_resp, 0);
      chk("t4_rrdy", r_addr_ready, 0);
      chk("t4_en", sram_en, 0);
    end
    @(posedge clock); #1 r_data_ready = 1;
    @(posedge clock); #1;
    do_read(32'h10, d, rs, lat);
    chk("t4_reread", d, 32'hDEADAAEF);

    do_read(32'h400, d, rs, lat);
    chk("t5_rd_err_resp", rs, 1);
    chk("t5_rd_err_data", d, 0);
    do_write(32'h3FC, 32'hCAFEF00D, 4'hF, rs, ix);
    chk("t5_wr_top_resp", rs, 0);
    chk("t5_wr_top_idx", ix, 8'hFF);
    do_write(32'h7FC, 32'h12345678, 4'hF, rs, ix);
    chk("t5_wr_err_resp", rs, 1);
    do_write(32'h3FC, 32'hFFFFFFFF, 4'h0, rs, ix);
    chk("t5_zero_strb_resp", rs, 0);
    do_read(32'h3FF, d, rs, lat);
    chk("t5_top_rdata", d, 32'hCAFEF00D);
    chk("t5_top_rresp", rs, 0);

    r_data_ready = 0;
    issue_read(32'h10);
    @(posedge clock); #2 resetn = 0;
    #1 chk("t6_valid_drop", r_data_valid, 0);
    repeat (2) @(posedge clock);
    #1 resetn = 1; r_data_ready = 1;
    @(negedge clock);
    chk("t6_no_beat", r_data_valid, 0);
    do_read(32'h10, d, rs, lat);
    chk("t6_rdata", d, 32'hDEADAAEF);
    chk("t6_rresp", rs, 0);

    repeat (2) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
